// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Sends a latched pattern MSB-first (bit len-1 first, bit 0 last), one bit per
// clk, repeated repeat_n times (0 = until abort) with `gap` idle cycles between
// repetitions. All outputs are registered.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     transmission request, sampled only in IDLE
//   pattern   bits to send
//   len       pattern length (0 = start ignored, >MAX_LEN clamps)
//   repeat_n  number of repetitions (0 = continuous)
//   gap       idle cycles between repetitions
//   abort     stop immediately (SEND/GAP only)
//   X         serial data bit, 0 whenever x_valid is 0
//   x_valid   X carries a pattern bit this cycle
//   busy      high in SEND or GAP
//   frame_st  high on the first bit of each repetition
//   done      one-cycle pulse after the final bit of the final repetition
module seq_pattern_gen #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned REP_W   = 4,
    parameter int unsigned GAP_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeat_n,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               X,
    output logic               x_valid,
    output logic               busy,
    output logic               frame_st,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [REP_W-1:0] REP_SAT = '1;

    state_t               state, state_nx;
    logic [MAX_LEN-1:0]   pat_q, pat_nx;
    logic [LEN_W-1:0]     len_q, len_nx;
    logic [REP_W-1:0]     rep_q, rep_nx;
    logic [GAP_W-1:0]     gap_q, gap_nx;
    logic [LEN_W-1:0]     idx, idx_nx;
    logic [REP_W-1:0]     rc, rc_nx;
    logic [GAP_W-1:0]     gcnt, gcnt_nx;
    logic                 x_nx, x_valid_nx, busy_nx, frame_st_nx, done_nx;

    logic [LEN_W-1:0]     len_clamp_c;
    logic [REP_W-1:0]     rc_inc_c;

    // Select bit i of p; shifting avoids an index wider than the vector needs.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] p,
                                      input logic [LEN_W-1:0]   i);
        logic [MAX_LEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    // Length clamp and saturating repetition count.
    always_comb begin
        len_clamp_c = (len > LEN_MAX) ? LEN_MAX : len;
        rc_inc_c    = (rc == REP_SAT) ? rc : rc + REP_W'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx    = state;
        pat_nx      = pat_q;
        len_nx      = len_q;
        rep_nx      = rep_q;
        gap_nx      = gap_q;
        idx_nx      = idx;
        rc_nx       = rc;
        gcnt_nx     = gcnt;
        x_nx        = 1'b0;
        x_valid_nx  = 1'b0;
        busy_nx     = busy;
        frame_st_nx = 1'b0;
        done_nx     = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy_nx = 1'b0;
                if (start && !abort && (len != '0)) begin
                    pat_nx      = pattern;
                    len_nx      = len_clamp_c;
                    rep_nx      = repeat_n;
                    gap_nx      = gap;
                    idx_nx      = len_clamp_c - LEN_W'(1);
                    rc_nx       = REP_W'(1);
                    state_nx    = S_SEND;
                    x_nx        = pick_bit(pattern, len_clamp_c - LEN_W'(1));
                    x_valid_nx  = 1'b1;
                    frame_st_nx = 1'b1;
                    busy_nx     = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                end else if (idx != '0) begin
                    idx_nx     = idx - LEN_W'(1);
                    x_nx       = pick_bit(pat_q, idx - LEN_W'(1));
                    x_valid_nx = 1'b1;
                end else if ((rep_q != '0) && (rc == rep_q)) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else if (gap_q != '0) begin
                    state_nx = S_GAP;
                    gcnt_nx  = gap_q;
                end else begin
                    // Back-to-back repetition, no idle cycle.
                    idx_nx      = len_q - LEN_W'(1);
                    rc_nx       = rc_inc_c;
                    x_nx        = pick_bit(pat_q, len_q - LEN_W'(1));
                    x_valid_nx  = 1'b1;
                    frame_st_nx = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                end else if (gcnt == GAP_W'(1)) begin
                    // Leaving at count 1 yields exactly `gap` idle cycles.
                    state_nx    = S_SEND;
                    idx_nx      = len_q - LEN_W'(1);
                    rc_nx       = rc_inc_c;
                    x_nx        = pick_bit(pat_q, len_q - LEN_W'(1));
                    x_valid_nx  = 1'b1;
                    frame_st_nx = 1'b1;
                end else begin
                    gcnt_nx = gcnt - GAP_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, latched parameters, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            idx      <= '0;
            rc       <= '0;
            gcnt     <= '0;
            X        <= 1'b0;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
            frame_st <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            pat_q    <= pat_nx;
            len_q    <= len_nx;
            rep_q    <= rep_nx;
            gap_q    <= gap_nx;
            idx      <= idx_nx;
            rc       <= rc_nx;
            gcnt     <= gcnt_nx;
            X        <= x_nx;
            x_valid  <= x_valid_nx;
            busy     <= busy_nx;
            frame_st <= frame_st_nx;
            done     <= done_nx;
        end
    end

endmodule
